// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential 64x64 signed multiplier between two requesters.
// Optional BUSY watchdog enabled by defining MUL_ARB_TIMEOUT_EN (aborts after TIMEOUT_CYC cycles).
module mul_arbiter #(
    parameter int W           = 64,
    parameter int TIMEOUT_CYC = 80
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           rsp0_valid,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp1_valid,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_err,
    output logic [W-1:0]   mul_multiplier,
    output logic [W-1:0]   mul_multiplicand,
    output logic           mul_op_start,
    output logic           mul_op_clear,
    input  logic           mul_op_done,
    input  logic [2*W-1:0] mul_result
);

    typedef enum logic [1:0] {IDLE, START, BUSY, CLEAR} state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             grant_q, grant_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             rsp0_q, rsp0_d;
    logic             rsp1_q, rsp1_d;
    logic             err_q, err_d;
    logic             winner;
    logic             accept;
    logic             timeoutHit;

    // rr_q names the requester that wins when both are asking
    assign winner = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign accept = (state_q == IDLE) && (req0_valid || req1_valid) && !reset;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeoutHit = (state_q == BUSY) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rsp0_q   <= rsp0_d;
            rsp1_q   <= rsp1_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rsp0_d   = 1'b0;
        rsp1_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = winner;
                    a_d     = winner ? req1_a : req0_a;
                    b_d     = winner ? req1_b : req0_b;
                    state_d = START;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                // A real completion takes priority over a watchdog expiring in the same cycle
                if (mul_op_done) begin
                    result_d = mul_result;
                    err_d    = 1'b0;
                    rsp0_d   = !grant_q;
                    rsp1_d   = grant_q;
                    state_d  = CLEAR;
                end else if (timeoutHit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    rsp0_d   = !grant_q;
                    rsp1_d   = grant_q;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                rr_d    = !grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req0_ready       = accept && !winner;
        req1_ready       = accept && winner;
        mul_op_start     = (state_q == START);
        mul_op_clear     = (state_q == CLEAR);
        mul_multiplier   = a_q;
        mul_multiplicand = b_q;
        rsp0_valid       = rsp0_q;
        rsp1_valid       = rsp1_q;
        rsp_result       = result_q;
        rsp_err          = err_q;
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: a behavioural multiplier answers each op_start after a fixed delay.
// Timeout scenario runs only when MUL_ARB_TIMEOUT_EN is defined.
module tb_mul_arbiter;

    localparam int EXP_LAT = 5;
    localparam int TO_LAT  = 82;
    localparam logic [127:0] FILL = {4{32'hA5A5_5A5A}};

    typedef struct {
        int           sel;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, rsp0_valid;
    logic          req1_valid, req1_ready, rsp1_valid;
    logic [63:0]   req0_a, req0_b, req1_a, req1_b;
    logic [127:0]  rsp_result;
    logic          rsp_err;
    logic [63:0]   mul_multiplier, mul_multiplicand;
    logic          mul_op_start, mul_op_clear;
    logic          mul_op_done = 1'b0;
    logic [127:0]  mul_result  = 128'h0;

    int totalCnt = 0;
    int badCnt   = 0;
    int cycleCnt = 0;
    int startCnt = 0;
    int clearCnt = 0;
    bit stallDone = 1'b0;
    bit mulBusy = 1'b0;
    int mulCnt = 0;
    logic signed [127:0] prod;

    mul_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
        .mul_op_done(mul_op_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (mul_op_start === 1'b1) startCnt <= startCnt + 1;
        if (mul_op_clear === 1'b1) clearCnt <= clearCnt + 1;
    end

    // Multiplier stand-in: done rises three negedges after op_start, drops on op_clear
    always @(negedge clk) begin
        if (reset) begin
            mulBusy = 1'b0;
            mul_op_done = 1'b0;
            mul_result = FILL;
        end else if (mul_op_clear) begin
            mulBusy = 1'b0;
            mul_op_done = 1'b0;
            mul_result = FILL;
        end else if (mul_op_start) begin
            mulBusy = 1'b1;
            mulCnt = 3;
            prod = $signed({{64{mul_multiplier[63]}}, mul_multiplier}) *
                   $signed({{64{mul_multiplicand[63]}}, mul_multiplicand});
        end else if (mulBusy && mulCnt > 0) begin
            mulCnt = mulCnt - 1;
            if (mulCnt == 0 && !stallDone) begin
                mul_op_done = 1'b1;
                mul_result = prod;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCnt++;
        if (act !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req0_ready"}, req0_ready, 0);
        checkOutput({tag, "_req1_ready"}, req1_ready, 0);
        checkOutput({tag, "_rsp0_valid"}, rsp0_valid, 0);
        checkOutput({tag, "_rsp1_valid"}, rsp1_valid, 0);
        checkOutput({tag, "_rsp_result"}, rsp_result, 0);
        checkOutput({tag, "_rsp_err"}, rsp_err, 0);
        checkOutput({tag, "_mul_multiplier"}, mul_multiplier, 0);
        checkOutput({tag, "_mul_multiplicand"}, mul_multiplicand, 0);
        checkOutput({tag, "_op_start"}, mul_op_start, 0);
        checkOutput({tag, "_op_clear"}, mul_op_clear, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitRsp(output bit got, output int who, output logic [127:0] res,
                           output logic err, input int budget);
        got = 1'b0;
        who = -1;
        res = '0;
        err = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid) begin
                got = 1'b1;
                who = (rsp0_valid && rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
                res = rsp_result;
                err = rsp_err;
            end
        end
    endtask

    task automatic applyStimulus(input string name, input int sel, input logic [63:0] a,
                                 input logic [63:0] b, input logic [127:0] expRes,
                                 input logic expErr, input int expLat);
        int n;
        int acc;
        bit got;
        int who;
        logic [127:0] res;
        logic err;
        @(negedge clk);
        if (sel == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        #1;
        n = 0;
        while (!(sel == 0 ? req0_ready : req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_ready"}, sel == 0 ? req0_ready : req1_ready, 1);
        checkOutput({name, "_otherReady"}, sel == 0 ? req1_ready : req0_ready, 0);
        acc = cycleCnt;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitRsp(got, who, res, err, 200);
        checkOutput({name, "_gotRsp"}, got, 1);
        checkOutput({name, "_who"}, who, sel);
        checkOutput({name, "_result"}, res, expRes);
        checkOutput({name, "_err"}, err, expErr);
        checkOutput({name, "_latency"}, cycleCnt - acc, expLat);
        @(negedge clk);
        #1;
        checkOutput({name, "_hold"}, rsp_result, expRes);
        checkOutput({name, "_pulseEnd"}, {rsp0_valid, rsp1_valid}, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int s0, c0, acc;
        bit got;
        int who;
        logic [127:0] res;
        logic err;
        int expWho[4];
        logic [127:0] expRes[2];

        vecs[0] = '{0, 64'h11, -64'sd3, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFCD};
        vecs[1] = '{1, 64'h11, 64'h43, 128'h473};
        vecs[2] = '{1, 64'h2, 64'h3, 128'h6};
        vecs[3] = '{0, -64'sd1, -64'sd1, 128'h1};
        vecs[4] = '{1, 64'h8000_0000_0000_0000, 64'h2, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
        vecs[5] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
        vecs[6] = '{0, 64'h0, -64'sd5, 128'h0};

        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 64'h1; req0_b = 64'h1;
        req1_valid = 1'b1; req1_a = 64'h1; req1_b = 64'h1;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;

        $display("[TB] simultaneous requests after reset");
        resetDut();
        s0 = startCnt;
        c0 = clearCnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'h11; req0_b = -64'sd3;
        req1_valid = 1'b1; req1_a = 64'h11; req1_b = 64'h43;
        #1;
        checkOutput("tie_ready0", req0_ready, 1);
        checkOutput("tie_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        waitRsp(got, who, res, err, 200);
        checkOutput("tie_first_who", who, 0);
        checkOutput("tie_first_result", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFCD);
        waitRsp(got, who, res, err, 200);
        checkOutput("tie_second_got", got, 1);
        checkOutput("tie_second_who", who, 1);
        checkOutput("tie_second_result", res, 128'h473);
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("tie_starts", startCnt - s0, 2);
        checkOutput("tie_clears", clearCnt - c0, 2);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
                          vecs[i].exp, 1'b0, EXP_LAT);
        end

        $display("[TB] both requesters held for four operations");
        resetDut();
        expWho = '{0, 1, 0, 1};
        expRes[0] = 128'hF;
        expRes[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2;
        s0 = startCnt;
        c0 = clearCnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'h3; req0_b = 64'h5;
        req1_valid = 1'b1; req1_a = -64'sd2; req1_b = 64'h7;
        for (int i = 0; i < 4; i++) begin
            waitRsp(got, who, res, err, 50);
            checkOutput($sformatf("rr%0d_who", i), who, expWho[i]);
            checkOutput($sformatf("rr%0d_result", i), res, expRes[expWho[i]]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rr_starts", startCnt - s0, 4);
        checkOutput("rr_clears", clearCnt - c0, 4);

        $display("[TB] reset while busy");
        resetDut();
        stallDone = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'h5; req0_b = 64'h5;
        #1;
        checkOutput("midreset_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("midreset_noRsp", {rsp0_valid, rsp1_valid}, 0);
        checkOutput("midreset_operandHeld", mul_multiplier, 64'h5);
        c0 = clearCnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkAllZero("midreset");
        reset = 1'b0;
        stallDone = 1'b0;
        checkOutput("midreset_noClear", clearCnt - c0, 0);
        applyStimulus("afterReset", 1, 64'h2, 64'h3, 128'h6, 1'b0, EXP_LAT);

`ifdef MUL_ARB_TIMEOUT_EN
        $display("[TB] watchdog abort");
        c0 = clearCnt;
        stallDone = 1'b1;
        applyStimulus("timeout", 1, 64'h7, 64'h7, 128'h0, 1'b1, TO_LAT);
        stallDone = 1'b0;
        checkOutput("timeout_clears", clearCnt - c0, 1);
        applyStimulus("afterTimeout", 0, 64'h3, 64'h3, 128'h9, 1'b0, EXP_LAT);
`else
        acc = TO_LAT;
`endif

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
